// File: rtl/rect_draw_engine.sv
// rect_draw_engine
// Rectangle rasteriser. It accepts fill, outline and full-frame clear
// commands over a valid/ready port. Each rectangle is clipped to the frame,
// then one pixel write per cycle is issued toward the framebuffer controller,
// and the engine stalls while the controller reports busy.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   cmd_valid/ready     command handshake
//   cmd_op              0=fill, 1=outline, 2=clear frame, 3=fill
//   cmd_x/y/w/h         top-left corner and size in pixels
//   cmd_color           pixel value written
//   abort               end the current command early
//   mem_wr/addr/wr_data write request; accepted when mem_wr & ~mem_busy
//   mem_busy            controller back-pressure
//   done, aborted       one-cycle completion pulse and its cause
//   pix_count           writes accepted for the current/last command
module rect_draw_engine #(
  parameter int FRAME_WIDTH  = 480,
  parameter int FRAME_HEIGHT = 272,
  parameter int COORD_WIDTH  = 10,
  parameter int ADDR_WIDTH   = 23,
  parameter int DATA_WIDTH   = 32,
  parameter int FB_BASE      = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [COORD_WIDTH-1:0] cmd_x,
  input  logic [COORD_WIDTH-1:0] cmd_y,
  input  logic [COORD_WIDTH-1:0] cmd_w,
  input  logic [COORD_WIDTH-1:0] cmd_h,
  input  logic [DATA_WIDTH-1:0]  cmd_color,
  input  logic                   abort,
  output logic                   mem_wr,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]  mem_wr_data,
  input  logic                   mem_busy,
  output logic                   done,
  output logic                   aborted,
  output logic [ADDR_WIDTH-1:0]  pix_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CLIP  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int CW1 = COORD_WIDTH + 1;
  localparam logic [CW1-1:0]         FW_C  = CW1'(FRAME_WIDTH);
  localparam logic [CW1-1:0]         FH_C  = CW1'(FRAME_HEIGHT);
  localparam logic [COORD_WIDTH-1:0] XMAX  = COORD_WIDTH'(FRAME_WIDTH - 1);
  localparam logic [COORD_WIDTH-1:0] YMAX  = COORD_WIDTH'(FRAME_HEIGHT - 1);
  localparam logic [ADDR_WIDTH-1:0]  PITCH = ADDR_WIDTH'(FRAME_WIDTH);
  localparam logic [ADDR_WIDTH-1:0]  BASE  = ADDR_WIDTH'(FB_BASE);

  logic [1:0]             r_state;
  logic                   r_mem_wr, r_done, r_aborted;
  logic [ADDR_WIDTH-1:0]  r_mem_addr, r_pix_count, r_row_base;
  logic [DATA_WIDTH-1:0]  r_mem_wr_data, r_color;
  logic [1:0]             r_op;
  logic [COORD_WIDTH-1:0] r_x, r_y, r_w, r_h;
  logic [COORD_WIDTH-1:0] r_x0, r_y0, r_x1, r_y1, r_cx, r_cy;

  assign cmd_ready   = (r_state == IDLE);
  assign mem_wr      = r_mem_wr;
  assign mem_addr    = r_mem_addr;
  assign mem_wr_data = r_mem_wr_data;
  assign done        = r_done;
  assign aborted     = r_aborted;
  assign pix_count   = r_pix_count;

  // Clip: one extra bit on the end coordinates so x+w / y+h cannot wrap.
  logic [CW1-1:0]         w_xend, w_yend;
  logic [COORD_WIDTH-1:0] w_x0, w_y0, w_x1, w_y1;
  logic                   w_empty;
  logic [ADDR_WIDTH-1:0]  w_row0;

  assign w_xend = {1'b0, r_x} + {1'b0, r_w};
  assign w_yend = {1'b0, r_y} + {1'b0, r_h};

  always_comb begin
    w_x0    = r_x;
    w_y0    = r_y;
    w_x1    = (w_xend > FW_C) ? XMAX : COORD_WIDTH'(w_xend - CW1'(1));
    w_y1    = (w_yend > FH_C) ? YMAX : COORD_WIDTH'(w_yend - CW1'(1));
    w_empty = (r_w == '0) || (r_h == '0) ||
              ({1'b0, r_x} >= FW_C) || ({1'b0, r_y} >= FH_C);
    if (r_op == 2'd2) begin
      w_x0    = '0;
      w_y0    = '0;
      w_x1    = XMAX;
      w_y1    = YMAX;
      w_empty = 1'b0;
    end
  end

  // Only the first row base needs a multiply; later rows add the pitch.
  assign w_row0 = BASE + ADDR_WIDTH'(w_y0) * PITCH;

  // Next-pixel walk
  logic                   w_accept, w_last, w_row_end, w_interior;
  logic [COORD_WIDTH-1:0] w_nx, w_ny;
  logic [ADDR_WIDTH-1:0]  w_nbase;

  assign w_accept   = r_mem_wr & ~mem_busy;
  assign w_row_end  = (r_cx == r_x1);
  assign w_last     = w_row_end && (r_cy == r_y1);
  // Interior rows of an outline only touch the two clipped edge columns.
  assign w_interior = (r_op == 2'd1) && (r_cy != r_y0) && (r_cy != r_y1);

  always_comb begin
    w_nx    = r_cx + COORD_WIDTH'(1);
    w_ny    = r_cy;
    w_nbase = r_row_base;
    if (w_row_end) begin
      w_nx    = r_x0;
      w_ny    = r_cy + COORD_WIDTH'(1);
      w_nbase = r_row_base + PITCH;
    end else if (w_interior && (r_cx == r_x0)) begin
      w_nx = r_x1;
    end
  end

  // Control state and write port
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_mem_wr      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wr_data <= '0;
      r_done        <= 1'b0;
      r_aborted     <= 1'b0;
      r_pix_count   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done    <= 1'b0;
          r_aborted <= 1'b0;
          if (cmd_valid) begin
            r_pix_count <= '0;
            r_state     <= CLIP;
          end
        end
        CLIP: begin
          if (abort) begin
            r_state   <= DONE;
            r_done    <= 1'b1;
            r_aborted <= 1'b1;
          end else if (w_empty) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_mem_wr      <= 1'b1;
            r_mem_addr    <= w_row0 + ADDR_WIDTH'(w_x0);
            r_mem_wr_data <= r_color;
            r_state       <= WRITE;
          end
        end
        WRITE: begin
          if (w_accept) begin
            r_pix_count <= r_pix_count + ADDR_WIDTH'(1);
            if (w_last || abort) begin
              // An abort coinciding with the final accept is a normal finish.
              r_mem_wr  <= 1'b0;
              r_state   <= DONE;
              r_done    <= 1'b1;
              r_aborted <= ~w_last;
            end else begin
              r_mem_addr <= w_nbase + ADDR_WIDTH'(w_nx);
            end
          end else if (abort) begin
            r_mem_wr  <= 1'b0;
            r_state   <= DONE;
            r_done    <= 1'b1;
            r_aborted <= 1'b1;
          end
        end
        default: begin
          r_done    <= 1'b0;
          r_aborted <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  // Command and walk registers; control above qualifies their use.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && cmd_valid) begin
      r_op    <= cmd_op;
      r_x     <= cmd_x;
      r_y     <= cmd_y;
      r_w     <= cmd_w;
      r_h     <= cmd_h;
      r_color <= cmd_color;
    end
    if (r_state == CLIP) begin
      r_x0       <= w_x0;
      r_y0       <= w_y0;
      r_x1       <= w_x1;
      r_y1       <= w_y1;
      r_cx       <= w_x0;
      r_cy       <= w_y0;
      r_row_base <= w_row0;
    end
    if (r_state == WRITE && w_accept) begin
      r_cx       <= w_nx;
      r_cy       <= w_ny;
      r_row_base <= w_nbase;
    end
  end

endmodule

// File: tb/tb_rect_draw_engine.sv
// Directed bench for rect_draw_engine: default 480x272 instance plus a small
// 8x4 instance at base 100 used for a complete frame clear.
module tb_rect_draw_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, cmd_valid, cmd_ready, abort, mem_wr, mem_busy, done, aborted;
  logic [1:0]  cmd_op;
  logic [9:0]  cmd_x, cmd_y, cmd_w, cmd_h;
  logic [31:0] cmd_color, mem_wr_data;
  logic [22:0] mem_addr, pix_count;

  logic        s_valid, s_ready, s_abort, s_wr, s_busy, s_done, s_aborted;
  logic [1:0]  s_op;
  logic [9:0]  s_x, s_y, s_w, s_h;
  logic [31:0] s_color, s_data;
  logic [22:0] s_addr, s_pix;

  rect_draw_engine dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_color(cmd_color), .abort(abort), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_busy(mem_busy), .done(done),
    .aborted(aborted), .pix_count(pix_count)
  );

  rect_draw_engine #(.FRAME_WIDTH(8), .FRAME_HEIGHT(4), .FB_BASE(100)) dut_s (
    .clk(clk), .reset(reset), .cmd_valid(s_valid), .cmd_ready(s_ready),
    .cmd_op(s_op), .cmd_x(s_x), .cmd_y(s_y), .cmd_w(s_w), .cmd_h(s_h),
    .cmd_color(s_color), .abort(s_abort), .mem_wr(s_wr), .mem_addr(s_addr),
    .mem_wr_data(s_data), .mem_busy(s_busy), .done(s_done),
    .aborted(s_aborted), .pix_count(s_pix)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [22:0] q_wr[$];
  logic [22:0] q_acc[$];
  int          first_wr, done_c;
  logic        ab_s;
  logic [31:0] first_data;

  logic [22:0] e_fill[6]  = '{23'd2410, 23'd2411, 23'd2412, 23'd2890, 23'd2891, 23'd2892};
  logic [22:0] e_clip[4]  = '{23'd130078, 23'd130079, 23'd130558, 23'd130559};
  logic [22:0] e_out[10]  = '{23'd0, 23'd1, 23'd2, 23'd3, 23'd480, 23'd483,
                              23'd960, 23'd961, 23'd962, 23'd963};
  logic [22:0] e_col[3]   = '{23'd0, 23'd480, 23'd960};
  logic [22:0] e_bpw[5]   = '{23'd0, 23'd0, 23'd0, 23'd0, 23'd1};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one command on the main instance and record every request cycle.
  // busy_mask[c] drives mem_busy in the c-th cycle after the handshake.
  task automatic run_cmd(input logic [1:0] op, input logic [9:0] x, input logic [9:0] y,
                         input logic [9:0] w, input logic [9:0] h, input logic [31:0] col,
                         input logic [63:0] busy_mask, input int limit);
    q_wr.delete();
    q_acc.delete();
    first_wr = -1;
    done_c   = -1;
    ab_s     = 1'b0;
    first_data = '0;
    @(negedge clk);
    cmd_op = op; cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_color = col;
    cmd_valid = 1'b1;
    mem_busy  = busy_mask[0];
    chk("ready_at_issue", cmd_ready, 1);
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      mem_busy  = (c < 64) ? busy_mask[c] : 1'b0;
      if (mem_wr) begin
        if (first_wr < 0) begin
          first_wr   = c;
          first_data = mem_wr_data;
        end
        q_wr.push_back(mem_addr);
        if (!mem_busy) q_acc.push_back(mem_addr);
      end
      if (done) begin
        done_c = c;
        ab_s   = aborted;
        break;
      end
    end
    mem_busy = 1'b0;
    chk("done_within_limit", (done_c > 0), 1);
    @(negedge clk);
    chk("done_single_cycle", done, 0);
    chk("ready_after_done", cmd_ready, 1);
    chk("no_wr_after_done", mem_wr, 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int dseen;
    logic [22:0] sq[$];

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_x = '0; cmd_y = '0;
    cmd_w = '0; cmd_h = '0; cmd_color = '0; abort = 1'b0; mem_busy = 1'b0;
    s_valid = 1'b0; s_op = '0; s_x = '0; s_y = '0; s_w = '0; s_h = '0;
    s_color = '0; s_abort = 1'b0; s_busy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_pix_count", pix_count, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wr_data", mem_wr_data, 0);
    reset = 1'b0;

    // Basic fill
    run_cmd(2'd0, 10'd10, 10'd5, 10'd3, 10'd2, 32'hFFFF0000, 64'd0, 40);
    chk("fill_nwr", q_wr.size(), 6);
    chk("fill_nacc", q_acc.size(), 6);
    for (int i = 0; i < 6; i++) chk($sformatf("fill_addr%0d", i), q_acc[i], e_fill[i]);
    chk("fill_first_latency", first_wr, 2);
    chk("fill_done_cycle", done_c, 8);
    chk("fill_data", first_data, 32'hFFFF0000);
    chk("fill_aborted", ab_s, 0);
    chk("fill_pix_count", pix_count, 6);

    // Clip at bottom-right corner
    run_cmd(2'd0, 10'd478, 10'd270, 10'd5, 10'd5, 32'h12345678, 64'd0, 40);
    chk("clip_nacc", q_acc.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("clip_addr%0d", i), q_acc[i], e_clip[i]);
    chk("clip_pix_count", pix_count, 4);

    // Empty commands
    run_cmd(2'd0, 10'd480, 10'd0, 10'd1, 10'd1, 32'h1, 64'd0, 20);
    chk("x480_nwr", q_wr.size(), 0);
    chk("x480_done_cycle", done_c, 2);
    chk("x480_pix_count", pix_count, 0);
    run_cmd(2'd0, 10'd0, 10'd0, 10'd0, 10'd1, 32'h1, 64'd0, 20);
    chk("w0_nwr", q_wr.size(), 0);
    chk("w0_done_cycle", done_c, 2);
    chk("w0_pix_count", pix_count, 0);

    // Outlines
    run_cmd(2'd1, 10'd0, 10'd0, 10'd4, 10'd3, 32'hA5A5A5A5, 64'd0, 40);
    chk("outl_nacc", q_acc.size(), 10);
    for (int i = 0; i < 10; i++) chk($sformatf("outl_addr%0d", i), q_acc[i], e_out[i]);
    chk("outl_pix_count", pix_count, 10);
    run_cmd(2'd1, 10'd0, 10'd0, 10'd1, 10'd3, 32'h5, 64'd0, 40);
    chk("col_nacc", q_acc.size(), 3);
    for (int i = 0; i < 3; i++) chk($sformatf("col_addr%0d", i), q_acc[i], e_col[i]);

    // Back-pressure on first request for 3 cycles
    run_cmd(2'd0, 10'd0, 10'd0, 10'd2, 10'd1, 32'h77, 64'h1C, 40);
    chk("bp_nwr", q_wr.size(), 5);
    for (int i = 0; i < 5; i++) chk($sformatf("bp_wr%0d", i), q_wr[i], e_bpw[i]);
    chk("bp_nacc", q_acc.size(), 2);
    chk("bp_acc0", q_acc[0], 0);
    chk("bp_acc1", q_acc[1], 1);
    chk("bp_pix_count", pix_count, 2);

    // Clear aborted while busy after 100 accepts
    @(negedge clk);
    cmd_op = 2'd2; cmd_valid = 1'b1;
    cnt = 0;
    for (int c = 0; c < 400 && cnt < 100; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (mem_wr && !mem_busy) cnt++;
    end
    chk("abort_reached_100", cnt, 100);
    @(negedge clk);
    mem_busy = 1'b1;
    abort    = 1'b1;
    chk("abort_pending_wr", mem_wr, 1);
    chk("abort_pending_addr", mem_addr, 100);
    @(negedge clk);
    chk("abort_wr_dropped", mem_wr, 0);
    chk("abort_done", done, 1);
    chk("abort_aborted", aborted, 1);
    chk("abort_pix_count", pix_count, 100);
    abort = 1'b0; mem_busy = 1'b0;
    @(negedge clk);
    chk("abort_done_clear", done, 0);
    chk("abort_ready", cmd_ready, 1);

    // Reset during a fill
    @(negedge clk);
    cmd_op = 2'd0; cmd_x = 10'd10; cmd_y = 10'd5; cmd_w = 10'd3; cmd_h = 10'd2;
    cmd_valid = 1'b1;
    @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_in_write", mem_wr, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstmid_mem_wr", mem_wr, 0);
    chk("rstmid_ready", cmd_ready, 1);
    chk("rstmid_pix_count", pix_count, 0);
    dseen = 0;
    for (int c = 0; c < 5; c++) begin
      if (done || mem_wr) dseen++;
      @(negedge clk);
    end
    chk("rstmid_quiet", dseen, 0);
    run_cmd(2'd0, 10'd10, 10'd5, 10'd3, 10'd2, 32'hFFFF0000, 64'd0, 40);
    chk("after_rst_nacc", q_acc.size(), 6);
    for (int i = 0; i < 6; i++) chk($sformatf("after_rst_addr%0d", i), q_acc[i], e_fill[i]);
    chk("after_rst_pix_count", pix_count, 6);

    // Full clear on the 8x4 instance (base 100): 32 writes 100..131
    @(negedge clk);
    s_op = 2'd2; s_color = 32'hDEADBEEF; s_valid = 1'b1;
    dseen = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      s_valid = 1'b0;
      if (s_wr && !s_busy) sq.push_back(s_addr);
      if (s_done) begin
        dseen = 1;
        chk("sclr_aborted", s_aborted, 0);
        break;
      end
    end
    chk("sclr_done_seen", dseen, 1);
    chk("sclr_nacc", sq.size(), 32);
    for (int i = 0; i < 32; i++) chk($sformatf("sclr_addr%0d", i), sq[i], 100 + i);
    chk("sclr_pix_count", s_pix, 32);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rect_draw_engine.md
Name: rect_draw_engine

Overview:
Parametrised rectangle rasteriser that replaces the fixed clear-plus-square drawing engine. It accepts draw commands (filled rectangle, rectangle outline, full-frame clear) through a valid/ready port. It clips each rectangle to the frame and emits one pixel write per cycle toward the framebuffer/SDRAM controller, honouring that controller's busy back-pressure. It sits between the command/control logic and the framebuffer write port.

Parameters:
FRAME_WIDTH, 480, pixels per line; also the row pitch in words
FRAME_HEIGHT, 272, lines per frame
COORD_WIDTH, 10, bit width of x/y/w/h command fields
ADDR_WIDTH, 23, framebuffer word address width
DATA_WIDTH, 32, pixel word width
FB_BASE, 0, word address of pixel (0,0)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  engine can accept a command
cmd_op  in  2  0=fill, 1=outline, 2=clear frame, 3=reserved (treated as fill)
cmd_x, cmd_y  in  COORD_WIDTH  top-left corner
cmd_w, cmd_h  in  COORD_WIDTH  width/height in pixels
cmd_color  in  DATA_WIDTH  pixel value
abort  in  1  stop the current command early
mem_wr  out  1  write request
mem_addr  out  ADDR_WIDTH  write address
mem_wr_data  out  DATA_WIDTH  write data
mem_busy  in  1  controller busy; a write is accepted in a cycle with mem_wr=1 and mem_busy=0
done  out  1  one-cycle pulse when a command finishes
aborted  out  1  valid with done; 1 if the command ended via abort
pix_count  out  ADDR_WIDTH  writes accepted for the current/last command

Behaviour:
- Reset (synchronous, highest priority, also mid-command):
  - state=IDLE; cmd_ready=1; mem_wr=0; mem_addr=0; mem_wr_data=0; done=0; aborted=0; pix_count=0.
  - Any in-flight request is dropped with no further writes.
- States: IDLE, CLIP, WRITE, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready: latch all cmd fields, clear pix_count, go to CLIP.
  - cmd_ready=0 in every other state.
- CLIP (1 cycle):
  - clear: x0=0, y0=0, x1=FRAME_WIDTH-1, y1=FRAME_HEIGHT-1; behaves as fill.
  - Otherwise: x1=min(x+w,FRAME_WIDTH)-1 and y1=min(y+h,FRAME_HEIGHT)-1. Sums are computed at COORD_WIDTH+1 bits so they do not wrap.
  - Empty if w=0, h=0, x>=FRAME_WIDTH or y>=FRAME_HEIGHT; empty goes to DONE with no writes.
  - Non-empty: row_base=FB_BASE+y0*FRAME_WIDTH (constant multiply), cur=(x0,y0). Go to WRITE with mem_wr=1, mem_addr=row_base+x0, mem_wr_data=color.
- Latency: first mem_wr is asserted 2 cycles after the command handshake cycle.
- WRITE:
  - mem_addr and mem_wr_data are held stable while mem_busy=1.
  - On accept: pix_count++, then advance to the next pixel.
  - Fill order: x0..x1 along the row, then next row with row_base+=FRAME_WIDTH. Row advance is incremental; no per-pixel multiply or divide.
  - Outline: every pixel on rows y0 and y1. On interior rows only x0 and x1 are written; the next address after x0 is row_base+x1.
  - Outline boundaries use the clipped edges. If x0=x1 the column is written once per row; if y0=y1 a single row is written. No pixel is written twice.
  - Back-to-back accepts give 1 pixel/cycle.
  - Accept of the last pixel goes to DONE; mem_wr=0 in the following cycle.
- abort:
  - Sampled in CLIP and WRITE.
  - In WRITE with mem_busy=1, the pending request is withdrawn (mem_wr=0 next cycle) and the engine goes to DONE with aborted=1.
  - If the pending pixel is accepted in the same cycle abort is high, it counts in pix_count and no further writes follow.
  - In CLIP: go to DONE with aborted=1.
  - Ignored in IDLE and DONE.
- DONE (1 cycle): done=1, aborted per cause; then IDLE with cmd_ready=1. pix_count holds until the next accepted command.
- Address arithmetic is ADDR_WIDTH bits and wraps modulo 2^ADDR_WIDTH; this is not checked.

Test Plan:
- Fill: op=0 at (10,5), w=3, h=2, color=FFFF0000, mem_busy=0 -> 6 writes on consecutive cycles at 2410, 2411, 2412, 2890, 2891, 2892. Then done=1 for 1 cycle, aborted=0, pix_count=6. First mem_wr is 2 cycles after the handshake.
- Clipping: fill at (478,270), w=h=5 -> writes only at 130078, 130079, 130558, 130559; pix_count=4. Also x=480 or w=0 -> no mem_wr, done 2 cycles after the handshake, pix_count=0.
- Outline: op=1 at (0,0), w=4, h=3 -> 10 writes, in order 0, 1, 2, 3, 480, 483, 960, 961, 962, 963. Also w=1, h=3 -> 3 writes at 0, 480, 960.
- Back-pressure: fill 2x1 at (0,0) with mem_busy high for 3 cycles on the first request -> mem_addr=0 held for 4 cycles, then 1. Exactly 2 accepts, no skipped or duplicated address.
- Clear + abort: op=2 -> 130560 writes, last address 130559, pix_count=130560. Repeat clear and raise abort while busy=1 after 100 accepts -> mem_wr drops next cycle, done=1 with aborted=1, pix_count=100.
- Reset mid-command: assert reset during WRITE of a fill -> next cycle mem_wr=0, cmd_ready=1, pix_count=0, no done pulse. A new command afterwards runs correctly.
